instr_seq_ctrl: RTL and testbench
=================================

Name: instr_seq_ctrl

Overview:
- Multi-cycle sequencer for the NPC core.
- Steps each instruction through fetch, decode, optional memory access and writeback.
- Drives the instruction-fetch and data-memory handshakes.
- Holds the instruction register feeding the combinational decoder, and gates register-file and PC write enables from the decoder's flags.
- Handles ebreak/illegal halts and keeps cycle/instret counters.

Parameters:
- CNT_W, 32: width of cycle and instret counters.
- RESET_IR, 32'h00000013: IR value at reset (addi x0,x0,0).
- TIMEOUT, 255: wait-cycle limit; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  leave IDLE and begin fetching.
- stop  in  1  sampled in WB; return to IDLE after the current instruction.
- if_req  out  1  fetch request.
- if_ready  in  1  fetch request accepted.
- if_rvalid  in  1  fetch data valid.
- if_rdata  in  32  fetched instruction.
- ir  out  32  instruction register, to decoder.
- dec_reg_write  in  1  decoder flag: write rd.
- dec_mem_read  in  1  decoder flag: load.
- dec_mem_write  in  1  decoder flag: store.
- dec_ebreak  in  1  decoder flag: ebreak.
- dec_illegal  in  1  decoder flag: unknown instruction.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1=store, 0=load; valid while dmem_req.
- dmem_ready  in  1  data request accepted.
- dmem_rvalid  in  1  load data valid.
- rf_we  out  1  register-file write pulse.
- pc_we  out  1  PC update pulse.
- halted  out  1  sticky halt flag.
- halt_code  out  2  00 none, 01 good trap, 10 illegal, 11 timeout.
- cycles  out  CNT_W  active-cycle count.
- instret  out  CNT_W  retired-instruction count.
- state  out  3  current FSM state (debug).

Behaviour:
- States, fixed encoding:
  - IDLE=0, FETCH=1, IF_WAIT=2, DECODE=3, MEM=4, MEM_WAIT=5, WB=6, HALT=7.
- Reset:
  - Asynchronous; on rst_n low the FSM goes to IDLE immediately, from any state.
  - ir=RESET_IR, halted=0, halt_code=00, cycles=0, instret=0.
  - All request and enable outputs are 0. Any outstanding memory transaction is abandoned.
- IDLE:
  - All outputs inactive.
  - start=1 -> FETCH.
- FETCH:
  - if_req=1, held until if_ready=1.
  - if_ready=1 and if_rvalid=1 in the same cycle: ir<=if_rdata, -> DECODE (zero-wait memory).
  - if_ready=1 only: -> IF_WAIT.
- IF_WAIT:
  - if_req=0.
  - Wait for if_rvalid=1, then ir<=if_rdata, -> DECODE.
  - if_rvalid is ignored in every other state.
- DECODE:
  - Exactly one cycle; ir is stable, and dec_* are consumed combinationally from it.
  - Priority: dec_illegal -> HALT, code 10. dec_ebreak -> HALT, code 01.
  - dec_mem_read and dec_mem_write both high -> HALT, code 10.
  - dec_mem_read or dec_mem_write -> MEM. Otherwise -> WB.
- MEM:
  - dmem_req=1, dmem_we=dec_mem_write, held until dmem_ready=1.
  - Store with ready -> WB.
  - Load with ready and dmem_rvalid in the same cycle -> WB; load with ready only -> MEM_WAIT.
- MEM_WAIT:
  - dmem_req=0.
  - Wait for dmem_rvalid=1, then -> WB.
- WB (one cycle):
  - rf_we=dec_reg_write; pc_we=1; instret increments.
  - stop=1 -> IDLE; otherwise -> FETCH.
- HALT:
  - halted=1; halt_code is held. start and stop are ignored.
  - Only reset exits HALT.
- ir changes only on accepted fetch data; it is stable from DECODE through WB.
- Counters:
  - cycles increments every cycle the state is neither IDLE nor HALT.
  - Both counters wrap modulo 2^CNT_W, with no saturation.
- rf_we and pc_we are high only in WB, so each is a single-cycle pulse per instruction.
- Latency with zero-wait memory:
  - ALU/jump instruction: FETCH, DECODE, WB = 3 cycles.
  - Load/store: 4 cycles.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A wait counter clears on every state change and increments while in FETCH, IF_WAIT, MEM or MEM_WAIT without progress.
  - When it reaches TIMEOUT -> HALT, code 11, with requests dropped that same cycle.
- MEM_TIMEOUT_EN undefined:
  - No wait counter; handshake waits are unbounded and code 11 is never produced.

Test Plan:
1. Reset, start=1, zero-wait fetch of addi (dec_reg_write=1), stop=1 -> states 1,3,6,0; rf_we and pc_we each pulse once; instret=1, cycles=3.
2. Store with dmem_ready delayed 2 cycles -> dmem_req held 3 cycles with dmem_we=1; WB then next FETCH; rf_we=0 in WB.
3. Load with dmem_ready, then dmem_rvalid 4 cycles later -> MEM_WAIT for 4 cycles; rf_we pulses after rvalid; cycles count includes the waits.
4. Fetch ebreak (0x00100073, dec_ebreak=1) -> HALT, halted=1, halt_code=01; a later start pulse leaves state=7 and counters frozen.
5. dec_illegal=1 together with dec_ebreak=1 -> halt_code=10; rst_n pulsed low mid-IF_WAIT -> state=0 and ir=0x00000013 immediately.
6. With MEM_TIMEOUT_EN and TIMEOUT=8, if_ready never asserted -> HALT with halt_code=11 after 8 FETCH cycles; with the macro undefined the bench stays in FETCH for 1000 cycles.

Source files
------------

// File: rtl/instr_seq_ctrl.sv
// Multi-cycle fetch/decode/mem/writeback sequencer for the NPC core.
// Optional handshake watchdog enabled by defining MEM_TIMEOUT_EN.
module instr_seq_ctrl #(
    parameter int unsigned CNT_W    = 32,
    parameter logic [31:0] RESET_IR = 32'h0000_0013,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    output logic             if_req,
    input  logic             if_ready,
    input  logic             if_rvalid,
    input  logic [31:0]      if_rdata,
    output logic [31:0]      ir,
    input  logic             dec_reg_write,
    input  logic             dec_mem_read,
    input  logic             dec_mem_write,
    input  logic             dec_ebreak,
    input  logic             dec_illegal,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ready,
    input  logic             dmem_rvalid,
    output logic             rf_we,
    output logic             pc_we,
    output logic             halted,
    output logic [1:0]       halt_code,
    output logic [CNT_W-1:0] cycles,
    output logic [CNT_W-1:0] instret,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_IF_WAIT  = 3'd2,
        S_DECODE   = 3'd3,
        S_MEM      = 3'd4,
        S_MEM_WAIT = 3'd5,
        S_WB       = 3'd6,
        S_HALT     = 3'd7
    } state_t;

    localparam logic [1:0] HC_NONE    = 2'b00;
    localparam logic [1:0] HC_TRAP    = 2'b01;
    localparam logic [1:0] HC_ILLEGAL = 2'b10;
    localparam logic [1:0] HC_TIMEOUT = 2'b11;

    state_t           state_q;
    state_t           state_d;
    logic [31:0]      ir_q;
    logic             ir_load;
    logic [1:0]       halt_code_q;
    logic [1:0]       halt_code_d;
    logic             halted_q;
    logic [CNT_W-1:0] cycles_q;
    logic [CNT_W-1:0] instret_q;
    logic             timeout_hit;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    logic [WAIT_W-1:0] wait_cnt_q;
    logic              in_wait_state;

    assign in_wait_state = (state_q == S_FETCH) || (state_q == S_IF_WAIT) ||
                           (state_q == S_MEM)   || (state_q == S_MEM_WAIT);
    // Timeout depends only on registered state so requests never combinationally follow ready.
    assign timeout_hit   = in_wait_state && (wait_cnt_q == WAIT_W'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else if ((state_d != state_q) || !in_wait_state) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
        end
    end
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign unused_timeout = |TIMEOUT;
`endif

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        halt_code_d = halt_code_q;
        ir_load     = 1'b0;
        if_req      = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        rf_we       = 1'b0;
        pc_we       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                if_req = 1'b1;
                if (if_ready) begin
                    if (if_rvalid) begin
                        ir_load = 1'b1;
                        state_d = S_DECODE;
                    end else begin
                        state_d = S_IF_WAIT;
                    end
                end
            end
            S_IF_WAIT: begin
                if (if_rvalid) begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec_illegal) begin
                    state_d     = S_HALT;
                    halt_code_d = HC_ILLEGAL;
                end else if (dec_ebreak) begin
                    state_d     = S_HALT;
                    halt_code_d = HC_TRAP;
                end else if (dec_mem_read && dec_mem_write) begin
                    state_d     = S_HALT;
                    halt_code_d = HC_ILLEGAL;
                end else if (dec_mem_read || dec_mem_write) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = dec_mem_write;
                if (dmem_ready) begin
                    // Stores need no response; loads finish early only on a zero-wait reply.
                    if (dec_mem_write || dmem_rvalid) state_d = S_WB;
                    else                               state_d = S_MEM_WAIT;
                end
            end
            S_MEM_WAIT: begin
                if (dmem_rvalid) state_d = S_WB;
            end
            S_WB: begin
                rf_we   = dec_reg_write;
                pc_we   = 1'b1;
                state_d = stop ? S_IDLE : S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (timeout_hit) begin
            state_d     = S_HALT;
            halt_code_d = HC_TIMEOUT;
            ir_load     = 1'b0;
            if_req      = 1'b0;
            dmem_req    = 1'b0;
            dmem_we     = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ir_q        <= RESET_IR;
            halt_code_q <= HC_NONE;
            halted_q    <= 1'b0;
            cycles_q    <= '0;
            instret_q   <= '0;
        end else begin
            state_q     <= state_d;
            halt_code_q <= halt_code_d;
            halted_q    <= halted_q | (state_d == S_HALT);
            if (ir_load) begin
                ir_q <= if_rdata;
            end
            if ((state_q != S_IDLE) && (state_q != S_HALT)) begin
                cycles_q <= cycles_q + CNT_W'(1);
            end
            if (state_q == S_WB) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    assign ir        = ir_q;
    assign halted    = halted_q;
    assign halt_code = halt_code_q;
    assign cycles    = cycles_q;
    assign instret   = instret_q;
    assign state     = state_q;

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Directed bench for instr_seq_ctrl; the bench plays both memories and the decoder.
// Build with MEM_TIMEOUT_EN defined to exercise the watchdog path instead of the unbounded wait.
module tb_instr_seq_ctrl;

    localparam logic [31:0] I_ADDI   = 32'h0050_0093;
    localparam logic [31:0] I_SW     = 32'h0011_2023;
    localparam logic [31:0] I_LW     = 32'h0001_2183;
    localparam logic [31:0] I_EBREAK = 32'h0010_0073;
    localparam logic [31:0] I_BAD    = 32'hFFFF_FFFF;
    localparam logic [31:0] I_NOP    = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        if_req;
    logic        if_ready;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic [31:0] ir;
    logic        dec_reg_write;
    logic        dec_mem_read;
    logic        dec_mem_write;
    logic        dec_ebreak;
    logic        dec_illegal;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;
    logic        dmem_rvalid;
    logic        rf_we;
    logic        pc_we;
    logic        halted;
    logic [1:0]  halt_code;
    logic [31:0] cycles;
    logic [31:0] instret;
    logic [2:0]  state;

    int n_vec  = 0;
    int n_miss = 0;

    instr_seq_ctrl #(
        .CNT_W   (32),
        .RESET_IR(32'h0000_0013),
        .TIMEOUT (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .if_req       (if_req),
        .if_ready     (if_ready),
        .if_rvalid    (if_rvalid),
        .if_rdata     (if_rdata),
        .ir           (ir),
        .dec_reg_write(dec_reg_write),
        .dec_mem_read (dec_mem_read),
        .dec_mem_write(dec_mem_write),
        .dec_ebreak   (dec_ebreak),
        .dec_illegal  (dec_illegal),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_ready   (dmem_ready),
        .dmem_rvalid  (dmem_rvalid),
        .rf_we        (rf_we),
        .pc_we        (pc_we),
        .halted       (halted),
        .halt_code    (halt_code),
        .cycles       (cycles),
        .instret      (instret),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dec(input logic rw, input logic mr, input logic mw,
                           input logic eb, input logic il);
        dec_reg_write = rw;
        dec_mem_read  = mr;
        dec_mem_write = mw;
        dec_ebreak    = eb;
        dec_illegal   = il;
    endtask

    // From IDLE: start, then a zero-wait fetch of instr; returns with the DUT in DECODE.
    task automatic start_and_fetch(input logic [31:0] instr);
        start = 1'b1;
        cyc();
        start     = 1'b0;
        if_ready  = 1'b1;
        if_rvalid = 1'b1;
        if_rdata  = instr;
        cyc();
        if_ready  = 1'b0;
        if_rvalid = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        if_ready    = 1'b0;
        if_rvalid   = 1'b0;
        if_rdata    = '0;
        dmem_ready  = 1'b0;
        dmem_rvalid = 1'b0;
        set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset state
        #12;
        check("rst_state",   state,     3'd0);
        check("rst_ir",      ir,        I_NOP);
        check("rst_halted",  halted,    1'b0);
        check("rst_code",    halt_code, 2'b00);
        check("rst_cycles",  cycles,    32'd0);
        check("rst_instret", instret,   32'd0);
        check("rst_reqs",    {if_req, dmem_req, rf_we, pc_we}, 4'b0000);
        rst_n = 1'b1;

        // 1: zero-wait ALU instruction, stop in WB
        start = 1'b1;
        #1;
        check("t1_idle", state, 3'd0);
        cyc();
        start     = 1'b0;
        if_ready  = 1'b1;
        if_rvalid = 1'b1;
        if_rdata  = I_ADDI;
        #1;
        check("t1_fetch",  state,  3'd1);
        check("t1_if_req", if_req, 1'b1);
        cyc();
        if_ready  = 1'b0;
        if_rvalid = 1'b0;
        set_dec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("t1_decode",   state, 3'd3);
        check("t1_ir",       ir,    I_ADDI);
        check("t1_dec_we",   {rf_we, pc_we}, 2'b00);
        cyc();
        stop = 1'b1;
        #1;
        check("t1_wb",       state, 3'd6);
        check("t1_wb_we",    {rf_we, pc_we}, 2'b11);
        cyc();
        stop = 1'b0;
        #1;
        check("t1_idle_end", state,   3'd0);
        check("t1_we_off",   {rf_we, pc_we}, 2'b00);
        check("t1_instret",  instret, 32'd1);
        check("t1_cycles",   cycles,  32'd3);

        // 2: store with dmem_ready two cycles late
        start_and_fetch(I_SW);
        set_dec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc();
        for (int i = 0; i < 3; i++) begin
            dmem_ready = (i == 2);
            #1;
            check("t2_mem_state", state, 3'd4);
            check("t2_mem_req",   {dmem_req, dmem_we}, 2'b11);
            cyc();
        end
        dmem_ready = 1'b0;
        #1;
        check("t2_wb",       state, 3'd6);
        check("t2_wb_we",    {rf_we, pc_we, dmem_req}, 3'b010);
        cyc();
        #1;
        check("t2_refetch",  state,   3'd1);
        check("t2_instret",  instret, 32'd2);
        check("t2_cycles",   cycles,  32'd9);

        // 3: fetch through IF_WAIT, load with 4-cycle MEM_WAIT
        if_ready = 1'b1;
        cyc();
        if_ready = 1'b0;
        #1;
        check("t3_if_wait",  state,  3'd2);
        check("t3_if_req0",  if_req, 1'b0);
        if_rvalid = 1'b1;
        if_rdata  = I_LW;
        cyc();
        if_rvalid = 1'b0;
        set_dec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check("t3_ir",       ir, I_LW);
        cyc();
        dmem_ready = 1'b1;
        #1;
        check("t3_mem_req",  {state, dmem_req, dmem_we}, {3'd4, 2'b10});
        cyc();
        dmem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dmem_rvalid = (i == 3);
            #1;
            check("t3_mem_wait", {state, dmem_req, rf_we}, {3'd5, 2'b00});
            cyc();
        end
        dmem_rvalid = 1'b0;
        stop        = 1'b1;
        #1;
        check("t3_wb",       {state, rf_we, pc_we}, {3'd6, 2'b11});
        check("t3_ir_hold",  ir, I_LW);
        cyc();
        stop = 1'b0;
        #1;
        check("t3_idle",     state,   3'd0);
        check("t3_cycles",   cycles,  32'd18);
        check("t3_instret",  instret, 32'd3);

        // 4: ebreak halts with good-trap code; start is ignored afterwards
        start_and_fetch(I_EBREAK);
        set_dec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc();
        #1;
        check("t4_halt",     state,     3'd7);
        check("t4_halted",   halted,    1'b1);
        check("t4_code",     halt_code, 2'b01);
        check("t4_cycles",   cycles,    32'd20);
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (3) cyc();
        #1;
        check("t4_stuck",    state,   3'd7);
        check("t4_frozen",   {cycles, instret}, {32'd20, 32'd3});
        check("t4_no_req",   {if_req, dmem_req, pc_we}, 3'b000);

        // 5: illegal wins over ebreak; both mem flags is illegal; async reset in IF_WAIT
        pulse_reset();
        #1;
        check("t5_rst_state",  state,  3'd0);
        check("t5_rst_halted", {halted, halt_code}, 3'b000);
        check("t5_rst_cycles", cycles, 32'd0);
        start_and_fetch(I_BAD);
        set_dec(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc();
        #1;
        check("t5_illegal",   {state, halt_code}, {3'd7, 2'b10});
        pulse_reset();
        start_and_fetch(32'h0000_0000);
        set_dec(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc();
        #1;
        check("t5_rw_both",   {state, halt_code}, {3'd7, 2'b10});
        pulse_reset();
        start_and_fetch(I_ADDI);
        set_dec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        cyc();
        if_ready = 1'b1;
        cyc();
        if_ready = 1'b0;
        #1;
        check("t5_in_if_wait", {state, ir}, {3'd2, I_ADDI});
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_async_state", state, 3'd0);
        check("t5_async_ir",    ir,    I_NOP);
        rst_n = 1'b1;
        set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // 6: fetch never accepted
        start = 1'b1;
        cyc();
        start = 1'b0;
`ifdef MEM_TIMEOUT_EN
        for (int i = 0; i < 20 && state != 3'd7; i++) cyc();
        #1;
        check("t6_timeout_state", state,     3'd7);
        check("t6_timeout_code",  halt_code, 2'b11);
        check("t6_timeout_req",   if_req,    1'b0);
`else
        repeat (1000) cyc();
        #1;
        check("t6_still_fetch",   {state, if_req}, {3'd1, 1'b1});
        check("t6_no_halt",       {halted, halt_code}, 3'b000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
